// File: rtl/zap_ptw_arb.sv
// Multi-requester page-table walker for the ZAP MMU: round-robin arbitration of
// TLB-miss walks, L1/L2 descriptor fetch over one Wishbone read master, ARM-style faults.
module zap_ptw_arb #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_mmu_en,
  input  logic [31:0]             i_baddr,
  input  logic [NUM_REQ-1:0]      i_req,
  input  logic [32*NUM_REQ-1:0]   i_req_va,
  output logic                    o_busy,
  output logic [NUM_REQ-1:0]      o_done,
  output logic [NUM_REQ-1:0]      o_fault,
  output logic [7:0]              o_fsr,
  output logic [31:0]             o_far,
  output logic [3:0]              o_tlb_wen,
  output logic [31:0]             o_tlb_va,
  output logic [31:0]             o_tlb_desc,
  output logic [3:0]              o_tlb_dac,
  output logic                    o_wb_cyc,
  output logic                    o_wb_stb,
  output logic [31:0]             o_wb_adr,
  output logic [3:0]              o_wb_sel,
  output logic                    o_wb_wen,
  input  logic [31:0]             i_wb_dat,
  input  logic                    i_wb_ack,
  input  logic                    i_wb_err
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {IDLE, L1_RD, L1_DEC, L2_RD, L2_DEC, RESP} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        gnt_q, gnt_d;
  logic [31:0]          va_q, va_d;
  logic [31:0]          desc_q, desc_d;
  logic [3:0]           dac_q, dac_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 flt_q, flt_d;
  logic [7:0]           fst_q, fst_d;
  logic                 cyc_q, cyc_d;
  logic [31:0]          adr_q, adr_d;
  logic                 busy_q, busy_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   fault_q, fault_d;
  logic [7:0]           fsr_q, fsr_d;
  logic [31:0]          far_q, far_d;
  logic [3:0]           twen_q, twen_d;
  logic [31:0]          tva_q, tva_d;
  logic [31:0]          tdesc_q, tdesc_d;
  logic [3:0]           tdac_q, tdac_d;

  logic [NUM_REQ-1:0]   req_eff;
  logic                 arb_found;
  logic [IW-1:0]        arb_sel;
  logic [31:0]          arb_va;
  logic                 tmo;
  logic                 unused_baddr;

  assign unused_baddr = ^i_baddr[13:0];

  // A requester whose pulse is on the outputs right now still holds i_req this cycle.
  assign req_eff = i_req & ~(done_q | fault_q);
  assign tmo     = ((CW+1)'(cnt_q) + (CW+1)'(1)) == (CW+1)'(TIMEOUT_CYC);

  // Round-robin pick: first pending requester at or after the pointer.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    arb_va    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      int unsigned k;
      k = 32'(ptr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!arb_found && req_eff[k]) begin
        arb_found = 1'b1;
        arb_sel   = IW'(k);
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (IW'(k) == arb_sel) arb_va = i_req_va[32*k +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    va_d    = va_q;
    desc_d  = desc_q;
    dac_d   = dac_q;
    cnt_d   = '0;
    flt_d   = flt_q;
    fst_d   = fst_q;
    cyc_d   = cyc_q;
    adr_d   = adr_q;
    done_d  = '0;
    fault_d = '0;
    fsr_d   = '0;
    far_d   = '0;
    twen_d  = '0;
    tva_d   = '0;
    tdesc_d = '0;
    tdac_d  = '0;

    unique case (state_q)
      IDLE: begin
        flt_d = 1'b0;
        fst_d = '0;
        if (i_mmu_en && arb_found) begin
          gnt_d   = arb_sel;
          va_d    = arb_va;
          ptr_d   = (32'(arb_sel) == NUM_REQ - 1) ? '0 : arb_sel + IW'(1);
          cyc_d   = 1'b1;
          adr_d   = {i_baddr[31:14], arb_va[31:20], 2'b00};
          state_d = L1_RD;
        end
      end
      L1_RD, L2_RD: begin
        cnt_d = cnt_q + CW'(1);
        if (i_wb_err || tmo) begin
          cyc_d   = 1'b0;
          cnt_d   = '0;
          flt_d   = 1'b1;
          fst_d   = (state_q == L1_RD) ? 8'h0C : {dac_q, 4'hE};
          state_d = RESP;
        end else if (i_wb_ack) begin
          cyc_d   = 1'b0;
          cnt_d   = '0;
          desc_d  = i_wb_dat;
          state_d = (state_q == L1_RD) ? L1_DEC : L2_DEC;
        end
      end
      L1_DEC: begin
        dac_d = desc_q[8:5];
        unique case (desc_q[1:0])
          2'b00: begin
            flt_d   = 1'b1;
            fst_d   = 8'h05;
            state_d = RESP;
          end
          2'b10: begin
            twen_d  = 4'b0001;
            tva_d   = va_q;
            tdesc_d = desc_q;
            tdac_d  = desc_q[8:5];
            state_d = RESP;
          end
          2'b01: begin
            adr_d   = {desc_q[31:10], va_q[19:12], 2'b00};
            cyc_d   = 1'b1;
            state_d = L2_RD;
          end
          default: begin
            adr_d   = {desc_q[31:12], va_q[19:10], 2'b00};
            cyc_d   = 1'b1;
            state_d = L2_RD;
          end
        endcase
      end
      L2_DEC: begin
        state_d = RESP;
        if (desc_q[1:0] == 2'b00) begin
          flt_d = 1'b1;
          fst_d = {dac_q, 4'h7};
        end else begin
          unique case (desc_q[1:0])
            2'b01:   twen_d = 4'b0100;
            2'b10:   twen_d = 4'b0010;
            default: twen_d = 4'b1000;
          endcase
          tva_d   = va_q;
          tdesc_d = desc_q;
          tdac_d  = dac_q;
        end
      end
      RESP: begin
        if (flt_q) begin
          fault_d = NUM_REQ'(1) << gnt_q;
          fsr_d   = fst_q;
          far_d   = va_q;
        end else begin
          done_d  = NUM_REQ'(1) << gnt_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      va_q    <= '0;
      desc_q  <= '0;
      dac_q   <= '0;
      cnt_q   <= '0;
      flt_q   <= 1'b0;
      fst_q   <= '0;
      cyc_q   <= 1'b0;
      adr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= '0;
      fault_q <= '0;
      fsr_q   <= '0;
      far_q   <= '0;
      twen_q  <= '0;
      tva_q   <= '0;
      tdesc_q <= '0;
      tdac_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      va_q    <= va_d;
      desc_q  <= desc_d;
      dac_q   <= dac_d;
      cnt_q   <= cnt_d;
      flt_q   <= flt_d;
      fst_q   <= fst_d;
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      fsr_q   <= fsr_d;
      far_q   <= far_d;
      twen_q  <= twen_d;
      tva_q   <= tva_d;
      tdesc_q <= tdesc_d;
      tdac_q  <= tdac_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_fault    = fault_q;
  assign o_fsr      = fsr_q;
  assign o_far      = far_q;
  assign o_tlb_wen  = twen_q;
  assign o_tlb_va   = tva_q;
  assign o_tlb_desc = tdesc_q;
  assign o_tlb_dac  = tdac_q;
  assign o_wb_cyc   = cyc_q;
  assign o_wb_stb   = cyc_q;
  assign o_wb_adr   = adr_q;
  assign o_wb_sel   = {4{cyc_q}};
  assign o_wb_wen   = 1'b0;

endmodule

// File: tb/tb_zap_ptw_arb.sv
// Directed bench for zap_ptw_arb: a small table-driven Wishbone slave plus
// hand-computed expectations for walks, faults, arbitration and reset.
module tb_zap_ptw_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        mmu_en;
  logic [31:0] baddr;
  logic [1:0]  req;
  logic [63:0] req_va;
  logic        busy;
  logic [1:0]  done, fault;
  logic [7:0]  fsr;
  logic [31:0] far;
  logic [3:0]  tlb_wen, tlb_dac;
  logic [31:0] tlb_va, tlb_desc;
  logic        wb_cyc, wb_stb, wb_wen;
  logic [31:0] wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_err;

  logic        ack_en, err_en;
  logic [31:0] err_adr;
  logic [31:0] tbl_adr [4];
  logic [31:0] tbl_dat [4];

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  pd, pf;
  int          lat, tw_n;
  logic [3:0]  tw_wen, tw_dac;
  logic [31:0] tw_va, tw_desc, tw_adr, p_far;
  logic [7:0]  p_fsr;
  logic [1:0]  order [5];

  always #5 clk = ~clk;

  zap_ptw_arb #(.NUM_REQ(2), .TIMEOUT_CYC(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_mmu_en(mmu_en), .i_baddr(baddr),
    .i_req(req), .i_req_va(req_va), .o_busy(busy), .o_done(done),
    .o_fault(fault), .o_fsr(fsr), .o_far(far), .o_tlb_wen(tlb_wen),
    .o_tlb_va(tlb_va), .o_tlb_desc(tlb_desc), .o_tlb_dac(tlb_dac),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_adr(wb_adr),
    .o_wb_sel(wb_sel), .o_wb_wen(wb_wen), .i_wb_dat(wb_dat),
    .i_wb_ack(wb_ack), .i_wb_err(wb_err)
  );

  // Zero-wait descriptor memory; unmapped addresses read as 0.
  always_comb begin
    wb_dat = 32'h0;
    for (int i = 0; i < 4; i++) if (tbl_adr[i] == wb_adr) wb_dat = tbl_dat[i];
  end
  assign wb_ack = wb_cyc & wb_stb & ack_en;
  assign wb_err = wb_cyc & wb_stb & err_en & (wb_adr == err_adr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_pulse();
    pd = '0; pf = '0; lat = 0; tw_n = 0;
    tw_wen = '0; tw_dac = '0; tw_va = '0; tw_desc = '0; tw_adr = '0;
    p_fsr = '0; p_far = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (wb_cyc) tw_adr = wb_adr;
      if (tlb_wen != 4'h0) begin
        tw_n++; tw_wen = tlb_wen; tw_va = tlb_va; tw_desc = tlb_desc; tw_dac = tlb_dac;
      end
      if ((done | fault) != 2'b00) begin
        pd = done; pf = fault; p_fsr = fsr; p_far = far;
        break;
      end
    end
  endtask

  // Requester withdraws right after the edge that ends its pulse cycle.
  task automatic drop(input int g);
    @(posedge clk);
    #1 req[g] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mmu_en = 1'b1; baddr = 32'h0000_4000; req = 2'b00; req_va = '0;
    ack_en = 1'b1; err_en = 1'b0; err_adr = '0;
    tbl_adr[0] = 32'h0000_448C; tbl_dat[0] = 32'h0010_0C02;
    tbl_adr[1] = 32'h0000_4010; tbl_dat[1] = 32'h0020_0021;
    tbl_adr[2] = 32'h0020_000C; tbl_dat[2] = 32'h8000_0FFE;
    tbl_adr[3] = 32'h0000_4014; tbl_dat[3] = 32'h0030_0061;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cyc", 32'(wb_cyc), 32'd0);
    chk("rst_adr", wb_adr, 32'h0);
    chk("rst_pulse", 32'({done, fault}), 32'd0);
    chk("rst_twen", 32'(tlb_wen), 32'd0);
    chk("rst_wen_sel", 32'({wb_wen, wb_sel}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Section walk on requester 0
    req_va[31:0] = 32'h1234_5678; req[0] = 1'b1;
    wait_pulse();
    chk("sec_done", 32'(pd), 32'd1);
    chk("sec_lat", 32'(lat), 32'd4);
    chk("sec_l1adr", tw_adr, 32'h0000_448C);
    chk("sec_twn", 32'(tw_n), 32'd1);
    chk("sec_wen", 32'(tw_wen), 32'h1);
    chk("sec_desc", tw_desc, 32'h0010_0C02);
    chk("sec_va", tw_va, 32'h1234_5678);
    drop(0);
    @(negedge clk);
    chk("no_regrant", 32'(busy), 32'd0);

    // Coarse L1 + small page on requester 1
    req_va[63:32] = 32'h0040_3000; req[1] = 1'b1;
    wait_pulse();
    chk("pg_done", 32'(pd), 32'd2);
    chk("pg_lat", 32'(lat), 32'd6);
    chk("pg_l2adr", tw_adr, 32'h0020_000C);
    chk("pg_wen", 32'(tw_wen), 32'h2);
    chk("pg_dac", 32'(tw_dac), 32'h1);
    chk("pg_desc", tw_desc, 32'h8000_0FFE);
    chk("pg_va", tw_va, 32'h0040_3000);
    drop(1);

    // Both requesters held: grants alternate starting at 0
    req = 2'b11;
    for (int n = 0; n < 4; n++) begin
      wait_pulse();
      order[n] = pd;
    end
    drop(1);
    wait_pulse();
    order[4] = pd;
    drop(0);
    chk("rr_0", 32'(order[0]), 32'd1);
    chk("rr_1", 32'(order[1]), 32'd2);
    chk("rr_2", 32'(order[2]), 32'd1);
    chk("rr_3", 32'(order[3]), 32'd2);
    chk("rr_4", 32'(order[4]), 32'd1);
    @(negedge clk);

    // L1 translation fault
    req_va[31:0] = 32'hF000_0000; req[0] = 1'b1;
    wait_pulse();
    chk("l1f_fault", 32'(pf), 32'd1);
    chk("l1f_done", 32'(pd), 32'd0);
    chk("l1f_fsr", 32'(p_fsr), 32'h05);
    chk("l1f_far", p_far, 32'hF000_0000);
    chk("l1f_twn", 32'(tw_n), 32'd0);
    chk("l1f_lat", 32'(lat), 32'd4);
    drop(0);
    @(negedge clk);

    // Bus error during L2 read (ack also offered; err wins)
    err_en = 1'b1; err_adr = 32'h0030_0000;
    req_va[31:0] = 32'h0050_0000; req[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("err_l2cyc", 32'(wb_cyc), 32'd1);
    chk("err_l2adr", wb_adr, 32'h0030_0000);
    @(negedge clk);
    chk("err_cycdrop", 32'({wb_cyc, wb_stb}), 32'd0);
    chk("err_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("err_fault", 32'(fault), 32'd1);
    chk("err_fsr", 32'(fsr), 32'h3E);
    chk("err_far", far, 32'h0050_0000);
    drop(0);
    err_en = 1'b0;
    @(negedge clk);
    chk("err_fsr_clr", 32'(fsr), 32'h0);

    // Timeout on L1 read
    ack_en = 1'b0;
    req_va[31:0] = 32'h1234_5678; req[0] = 1'b1;
    repeat (8) @(negedge clk);
    chk("tmo_wait7", 32'(wb_cyc), 32'd1);
    @(negedge clk);
    chk("tmo_drop", 32'(wb_cyc), 32'd0);
    @(negedge clk);
    chk("tmo_fault", 32'(fault), 32'd1);
    chk("tmo_fsr", 32'(fsr), 32'h0C);
    drop(0);
    ack_en = 1'b1;
    @(negedge clk);

    // MMU disabled: request stays pending; change mid-walk ignored
    mmu_en = 1'b0; req[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("dis_busy", 32'({busy, wb_cyc}), 32'd0);
    mmu_en = 1'b1;
    @(negedge clk);
    chk("en_busy", 32'(busy), 32'd1);
    mmu_en = 1'b0;
    wait_pulse();
    chk("en_done", 32'(pd), 32'd1);
    drop(0);
    mmu_en = 1'b1;
    @(negedge clk);

    // Reset during L2 read, then re-walk from L1
    req_va[31:0] = 32'h0040_3000; req[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rw_l2", wb_adr, 32'h0020_000C);
    rst = 1'b1;
    #1;
    chk("rw_cyc", 32'({wb_cyc, wb_stb, busy}), 32'd0);
    @(negedge clk);
    chk("rw_nopulse", 32'({done, fault}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rw_l1adr", wb_adr, 32'h0000_4010);
    chk("rw_l1cyc", 32'(wb_cyc), 32'd1);
    wait_pulse();
    chk("rw_done", 32'(pd), 32'd1);
    chk("rw_wen", 32'(tw_wen), 32'h2);
    drop(0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
